rs_cmd_pulser: RTL and testbench

- Upstream stage for the gate-level RS latch. Turns two raw request lines into clean, qualified, mutually exclusive set/reset pulses that drive the latch's set and reset inputs.
- Each request must be stable for a programmable number of cycles before it acts.
- Each output pulse has a guaranteed minimum width, enough to cover the latch's NOR gate delays.
- A hold-off window follows each pulse. The block never drives the forbidden S=R=1 combination.

---
 rtl/rs_cmd_pulser_if.sv | 32 +++
 rtl/rs_cmd_pulser.sv | 167 ++++++++++++++++
 tb/tb_rs_cmd_pulser.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rs_cmd_pulser_if.sv
// rs_cmd_pulser_if: request/pulse bundle between a requester and rs_cmd_pulser.
//   set_req, rst_req : raw level requests (driven by master)
//   latch_set        : qualified set pulse to the RS latch (driven by slave)
//   latch_reset      : qualified reset pulse to the RS latch (driven by slave)
//   busy             : pulser FSM not idle (driven by slave)
//   conflict         : both requests seen high together (driven by slave)
interface rs_cmd_pulser_if;
  logic set_req;
  logic rst_req;
  logic latch_set;
  logic latch_reset;
  logic busy;
  logic conflict;

  modport master (
    output set_req,
    output rst_req,
    input  latch_set,
    input  latch_reset,
    input  busy,
    input  conflict
  );

  modport slave (
    input  set_req,
    input  rst_req,
    output latch_set,
    output latch_reset,
    output busy,
    output conflict
  );
endinterface

// File: rtl/rs_cmd_pulser.sv
// rs_cmd_pulser: debounces two raw request lines and emits clean, mutually exclusive,
// minimum-width set/reset pulses for a gate-level RS latch, followed by a hold-off window.
//   clock : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : rs_cmd_pulser_if.slave (set_req/rst_req in; latch_set/latch_reset/busy/conflict out)
// Build option: define RS_PRIORITY_RESET_EN to resolve both-high requests as a reset command
// (conflict then tied low); otherwise both-high is ignored and flagged on conflict.
module rs_cmd_pulser #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2,
  parameter int unsigned HOLDOFF_CYCLES  = 2,
  parameter int unsigned CNT_W           = 8
) (
  input  logic           clock,
  input  logic           reset,
  rs_cmd_pulser_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StQual, StPulse, StHold} state_e;

  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PulLast  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_q, cmd_d;  // 0: set command, 1: reset command
  logic             s_set_q, s_rst_q;
  logic             latch_set_q, latch_set_d;
  logic             latch_reset_q, latch_reset_d;
  logic             busy_q, busy_d;
  logic             conflict_q, conflict_d;
  logic             conflict_raw;
  logic             cmd_smp;

  assign cmd_smp = cmd_q ? s_rst_q : s_set_q;

`ifndef RS_PRIORITY_RESET_EN
  logic oth_smp;
  assign oth_smp = cmd_q ? s_set_q : s_rst_q;
`endif

  // State, sample and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      cmd_q         <= 1'b0;
      s_set_q       <= 1'b0;
      s_rst_q       <= 1'b0;
      latch_set_q   <= 1'b0;
      latch_reset_q <= 1'b0;
      busy_q        <= 1'b0;
      conflict_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      s_set_q       <= bus.set_req;
      s_rst_q       <= bus.rst_req;
      latch_set_q   <= latch_set_d;
      latch_reset_q <= latch_reset_d;
      busy_q        <= busy_d;
      conflict_q    <= conflict_d;
    end
  end

  // Next-state logic; all decisions use the sampled requests.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    conflict_raw = 1'b0;
    unique case (state_q)
      StIdle: begin
`ifdef RS_PRIORITY_RESET_EN
        if (s_rst_q) begin
          cmd_d   = 1'b1;
          cnt_d   = '0;
          state_d = StQual;
        end else if (s_set_q) begin
          cmd_d   = 1'b0;
          cnt_d   = '0;
          state_d = StQual;
        end
`else
        if (s_set_q && s_rst_q) begin
          conflict_raw = 1'b1;
        end else if (s_set_q || s_rst_q) begin
          cmd_d   = s_rst_q;
          cnt_d   = '0;
          state_d = StQual;
        end
`endif
      end
      StQual: begin
`ifdef RS_PRIORITY_RESET_EN
        if (!cmd_q && s_rst_q) begin
          // A reset request pre-empts a qualifying set and restarts debounce.
          cmd_d = 1'b1;
          cnt_d = '0;
        end else if (!cmd_smp) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StPulse;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
`else
        if (!cmd_smp || oth_smp) begin
          state_d      = StIdle;
          cnt_d        = '0;
          conflict_raw = oth_smp;
        end else if (cnt_q == DebLast) begin
          state_d = StPulse;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
`endif
      end
      StPulse: begin
        if (cnt_q == PulLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHold: begin
        if (cnt_q != HoldLast) begin
          cnt_d = cnt_q + CntOne;
        end
        // Leaving needs a released request, so a held request pulses only once.
        if (cnt_q == HoldLast && !cmd_smp) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs derive from the next state; one cmd bit keeps them exclusive.
  always_comb begin
    latch_set_d   = (state_d == StPulse) && !cmd_d;
    latch_reset_d = (state_d == StPulse) && cmd_d;
    busy_d        = (state_d != StIdle);
`ifdef RS_PRIORITY_RESET_EN
    conflict_d    = 1'b0;
`else
    conflict_d    = conflict_raw;
`endif
  end

  assign bus.latch_set   = latch_set_q;
  assign bus.latch_reset = latch_reset_q;
  assign bus.busy        = busy_q;
  assign bus.conflict    = conflict_q;

endmodule

// File: tb/tb_rs_cmd_pulser.sv
// tb_rs_cmd_pulser: self-checking bench for rs_cmd_pulser (default parameters plus a
// DEBOUNCE_CYCLES=1/PULSE_CYCLES=1 instance for random traffic). Honours RS_PRIORITY_RESET_EN.
module tb_rs_cmd_pulser;

  logic clock;
  logic reset;
  logic reset2;

  rs_cmd_pulser_if bus ();
  rs_cmd_pulser_if bus2 ();

  rs_cmd_pulser dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  rs_cmd_pulser #(
    .DEBOUNCE_CYCLES (1),
    .PULSE_CYCLES    (1),
    .HOLDOFF_CYCLES  (2),
    .CNT_W           (8)
  ) dut2 (
    .clock (clock),
    .reset (reset2),
    .bus   (bus2.slave)
  );

  typedef struct {
    int   n;
    logic sr, rr, rs;
    logic es, er, eb, ec;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int n, input logic sr, input logic rr, input logic rs,
                              input logic es, input logic er, input logic eb, input logic ec);
    vec_t v;
    v.n = n; v.sr = sr; v.rr = rr; v.rs = rs;
    v.es = es; v.er = er; v.eb = eb; v.ec = ec;
    vecs.push_back(v);
  endfunction

  initial begin
    int   rise[2];
    int   width[2];
    int   np;
    logic prev;
    int   run_s, run_r, pulses;

    bus.set_req  = 1'b1;
    bus.rst_req  = 1'b1;
    bus2.set_req = 1'b0;
    bus2.rst_req = 1'b0;
    reset        = 1'b1;
    reset2       = 1'b1;

    // Reset with both requests high: everything must stay low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("reset_latch_set", int'(bus.latch_set), 0);
      chk("reset_latch_reset", int'(bus.latch_reset), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_conflict", int'(bus.conflict), 0);
    end

    // Held set: rise at edge 5, fall at edge 7, idle again at edge 13.
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(4, 1, 0, 0, 0, 0, 1, 0);
    add(2, 1, 0, 0, 1, 0, 1, 0);
    add(5, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(2, 0, 0, 0, 0, 0, 0, 0);
    // Two-cycle glitch: QUAL then abort, busy falls 3 edges after glitch start.
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(2, 0, 0, 0, 0, 0, 0, 0);
    // Both requests high for 6 cycles.
`ifdef RS_PRIORITY_RESET_EN
    add(1, 1, 1, 0, 0, 0, 0, 0);
    add(4, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0);
    add(2, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
`else
    add(1, 1, 1, 0, 0, 0, 0, 0);
    add(5, 1, 1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(3, 0, 0, 0, 0, 0, 0, 0);
`endif
    // Qualified reset request, then reset asserted while latch_reset is high.
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(4, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(4, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[r]) begin
      for (int k = 0; k < vecs[r].n; k++) begin
        bus.set_req = vecs[r].sr;
        bus.rst_req = vecs[r].rr;
        reset       = vecs[r].rs;
        @(posedge clock); #1;
        chk($sformatf("row%0d_latch_set", r), int'(bus.latch_set), int'(vecs[r].es));
        chk($sformatf("row%0d_latch_reset", r), int'(bus.latch_reset), int'(vecs[r].er));
        chk($sformatf("row%0d_busy", r), int'(bus.busy), int'(vecs[r].eb));
        chk($sformatf("row%0d_conflict", r), int'(bus.conflict), int'(vecs[r].ec));
      end
    end

    // Press rst_req 8 cycles, release 3, press again 8 cycles: two separate pulses.
    np   = 0;
    prev = 1'b0;
    rise[0] = -1; rise[1] = -1; width[0] = -1; width[1] = -1;
    for (int c = 0; c < 40; c++) begin
      bus.set_req = 1'b0;
      bus.rst_req = (c < 8) || (c >= 11 && c < 19);
      @(posedge clock); #1;
      if (bus.latch_set !== 1'b0) chk("repress_no_set", int'(bus.latch_set), 0);
      if (bus.latch_reset && !prev) begin
        if (np < 2) rise[np] = c;
        np++;
      end else if (!bus.latch_reset && prev && np >= 1 && np <= 2) begin
        width[np-1] = c - rise[np-1];
      end
      prev = bus.latch_reset;
    end
    chk("repress_pulse_count", np, 2);
    chk("repress_rise0", rise[0], 5);
    chk("repress_width0", width[0], 2);
    chk("repress_rise1", rise[1], 16);
    chk("repress_width1", width[1], 2);
    chk("repress_gap_ok", int'((rise[1] - (rise[0] + width[0])) >= 7), 1);

    // Random traffic on the short-pulse instance.
    reset2 = 1'b0;
    run_s  = 0;
    run_r  = 0;
    pulses = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) bus2.set_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bus2.rst_req = 1'($urandom_range(0, 1));
      reset2 = ($urandom_range(0, 63) == 0);
      @(posedge clock); #1;
      chk("rand_exclusive", int'(bus2.latch_set & bus2.latch_reset), 0);
      if (bus2.latch_set) begin
        run_s++;
      end else if (run_s != 0) begin
        chk("rand_set_width", run_s, 1);
        pulses++;
        run_s = 0;
      end
      if (bus2.latch_reset) begin
        run_r++;
      end else if (run_r != 0) begin
        chk("rand_reset_width", run_r, 1);
        pulses++;
        run_r = 0;
      end
    end
    chk("rand_saw_pulses", int'(pulses > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
